// File: rtl/mul_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl_if
// Purpose : request/response handshake bundle between a client and the
//           multiplier issue controller.
// Signals :
//   req_valid / req_ready  request handshake, client -> controller
//   req_a / req_b          signed 32-bit operands
//   req_tag                request tag (MUL_ISSUE_TAG_EN builds only)
//   rsp_valid / rsp_ready  response handshake, controller -> client
//   rsp_prod               signed 64-bit product at the response head
//   rsp_tag                tag at the response head (MUL_ISSUE_TAG_EN only)
// Modports: master = client side, slave = controller side.
// Build option: define MUL_ISSUE_TAG_EN to add the tag signals.
// ---------------------------------------------------------------------------
interface mul_issue_ctrl_if
`ifdef MUL_ISSUE_TAG_EN
  #(parameter int TAG_W = 4)
`endif
  ;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_prod;
`ifdef MUL_ISSUE_TAG_EN
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] rsp_tag;

  modport master (output req_valid, req_a, req_b, req_tag, rsp_ready,
                  input  req_ready, rsp_valid, rsp_prod, rsp_tag);
  modport slave  (input  req_valid, req_a, req_b, req_tag, rsp_ready,
                  output req_ready, rsp_valid, rsp_prod, rsp_tag);
`else
  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_prod);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_prod);
`endif
endinterface

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
// Purpose : issue/response controller wrapped around a pipelined 32x32 signed
//           Booth multiplier. One operation is in flight at a time; operands
//           are registered and held on o_mul_in0/o_mul_in1 for the whole
//           flight, the latency is counted down, and the 64-bit product is
//           captured into a small circular response FIFO.
// Ports   :
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   bus (slave)       request/response handshake, see mul_issue_ctrl_if
//   o_mul_in0/1       held operands to the multiplier
//   i_mul_result      multiplier product, valid MUL_LATENCY edges after launch
//   o_busy            an operation is in flight
// Build option: define MUL_ISSUE_TAG_EN to carry a per-request tag through
//           the FIFO alongside the product.
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int RSP_DEPTH   = 2
`ifdef MUL_ISSUE_TAG_EN
  ,
  parameter int TAG_W       = 4
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mul_issue_ctrl_if.slave   bus,
  output logic [31:0]       o_mul_in0,
  output logic [31:0]       o_mul_in1,
  input  logic [63:0]       i_mul_result,
  output logic              o_busy
);

  localparam int CNT_W  = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int FCNT_W = $clog2(RSP_DEPTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state, w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
  logic [FCNT_W-1:0] r_count;
  logic [63:0]       r_memProd [RSP_DEPTH];
  logic              w_accept, w_push, w_pop, w_fifoFull, w_fifoEmpty;
`ifdef MUL_ISSUE_TAG_EN
  logic [TAG_W-1:0]  r_tagQ;
  logic [TAG_W-1:0]  r_memTag [RSP_DEPTH];
`endif

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_fifoFull  = (r_count == FCNT_W'(RSP_DEPTH));
  assign w_fifoEmpty = (r_count == '0);
  assign w_pop       = !w_fifoEmpty && bus.rsp_ready;

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state and handshake decode. A request is only taken while the FIFO
  // has room, which together with the single-op limit makes overflow
  // impossible. The push happens on the edge where the countdown is at zero.
  always_comb begin
    w_nextState   = r_state;
    bus.req_ready = 1'b0;
    o_busy        = 1'b0;
    w_accept      = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = !w_fifoFull;
        w_accept      = bus.req_valid && !w_fifoFull;
        if (w_accept) w_nextState = BUSY;
      end
      BUSY: begin
        o_busy = 1'b1;
        if (r_cnt == '0) begin
          w_push      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand launch and latency countdown. The operands only change on an
  // accepted request, so the multiplier inputs stay quiet in IDLE and stable
  // through the whole flight even if the client wiggles req_a/req_b.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mul_in0 <= '0;
      o_mul_in1 <= '0;
      r_cnt     <= '0;
`ifdef MUL_ISSUE_TAG_EN
      r_tagQ    <= '0;
`endif
    end else if (w_accept) begin
      o_mul_in0 <= bus.req_a;
      o_mul_in1 <= bus.req_b;
      r_cnt     <= CNT_W'(MUL_LATENCY);
`ifdef MUL_ISSUE_TAG_EN
      r_tagQ    <= bus.req_tag;
`endif
    end else if (r_state == BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // FIFO pointers and occupancy. Simultaneous push and pop leave the count
  // alone while both pointers advance; a pop on an empty FIFO never happens
  // because w_pop is qualified by the non-empty flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= ptrInc(r_wrPtr);
      if (w_pop)  r_rdPtr <= ptrInc(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only visible through the head
  // while the count says they hold data.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memProd[r_wrPtr] <= i_mul_result;
`ifdef MUL_ISSUE_TAG_EN
      r_memTag[r_wrPtr]  <= r_tagQ;
`endif
    end
  end

  // Head presentation; forced to zero when empty so the reset view is clean.
  assign bus.rsp_valid = !w_fifoEmpty;
  assign bus.rsp_prod  = w_fifoEmpty ? '0 : r_memProd[r_rdPtr];
`ifdef MUL_ISSUE_TAG_EN
  assign bus.rsp_tag   = w_fifoEmpty ? '0 : r_memTag[r_rdPtr];
`endif

`ifndef SYNTHESIS
  // A push into a full FIFO would mean the accept gating is broken.
  assert property (@(posedge i_clk) disable iff (i_rst) !(w_push && w_fifoFull));
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_issue_ctrl
// Directed bench for mul_issue_ctrl with a 3-stage multiplier stand-in.
// ---------------------------------------------------------------------------
module tb_mul_issue_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] mulIn0, mulIn1;
  logic [63:0] mulResult;
  logic        busy;
  logic [63:0] mulS1, mulS2, mulS3;
  logic [3:0]  reqTag;
  int          totalChecks;
  int          badChecks;

`ifdef MUL_ISSUE_TAG_EN
  mul_issue_ctrl_if #(.TAG_W(4)) intf ();
`else
  mul_issue_ctrl_if intf ();
`endif

  mul_issue_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (intf),
    .o_mul_in0    (mulIn0),
    .o_mul_in1    (mulIn1),
    .i_mul_result (mulResult),
    .o_busy       (busy)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-register signed multiplier stand-in sharing the controller's reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mulS1 <= '0;
      mulS2 <= '0;
      mulS3 <= '0;
    end else begin
      mulS1 <= {{32{mulIn0[31]}}, mulIn0} * {{32{mulIn1[31]}}, mulIn1};
      mulS2 <= mulS1;
      mulS3 <= mulS2;
    end
  end
  assign mulResult = mulS3;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] tag);
    intf.req_valid = valid;
    intf.req_a     = a;
    intf.req_b     = b;
    reqTag         = tag;
`ifdef MUL_ISSUE_TAG_EN
    intf.req_tag   = tag;
`endif
  endtask

  // Present a request, wait (bounded) for ready, let the edge take it.
  // Returns just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    applyStimulus(1'b1, a, b, tag);
    while (!intf.req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) checkOutput("issue_timeout", 64'd0, 64'd1);
    step();
    intf.req_valid = 1'b0;
  endtask

  // Issue one op with rsp_ready high; report product, latency in cycles
  // after the accept edge, and number of sampled busy cycles.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] prod, output int lat, output int busyCnt);
    prod    = '0;
    lat     = -1;
    busyCnt = 0;
    issue(a, b, 4'h0);
    for (int i = 0; i < 8; i++) begin
      if (busy) busyCnt++;
      if (intf.rsp_valid && lat < 0) begin
        lat  = i;
        prod = intf.rsp_prod;
      end
      step();
    end
  endtask

  initial begin
    logic [63:0] prod;
    int          lat, busyCnt, seen;
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1;
    intf.rsp_ready = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'h0);
    #12;

    // Reset state
    checkOutput("rst_rsp_valid", 64'(intf.rsp_valid), 64'd0);
    checkOutput("rst_rsp_prod",  intf.rsp_prod, 64'd0);
    checkOutput("rst_busy",      64'(busy), 64'd0);
    checkOutput("rst_req_ready", 64'(intf.req_ready), 64'd1);
    checkOutput("rst_mul_in0",   64'(mulIn0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // T1 basic
    runOp(32'd7, 32'd6, prod, lat, busyCnt);
    checkOutput("t1_prod",    prod, 64'd42);
    checkOutput("t1_latency", 64'(lat), 64'd4);
    checkOutput("t1_busy",    64'(busyCnt), 64'd4);
    checkOutput("t1_drained", 64'(intf.rsp_valid), 64'd0);

    // T2 signed
    runOp(-32'sd3, 32'd5, prod, lat, busyCnt);
    checkOutput("t2_neg", prod, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(32'h8000_0000, 32'h8000_0000, prod, lat, busyCnt);
    checkOutput("t2_minmin", prod, 64'h4000_0000_0000_0000);

    // T3 backpressure
    intf.rsp_ready = 1'b0;
    issue(32'd2, 32'd10, 4'h0);
    repeat (4) step();
    issue(32'd3, 32'd10, 4'h0);
    repeat (4) step();
    applyStimulus(1'b1, 32'd4, 32'd10, 4'h0);
    step(); step();
    checkOutput("t3_full_ready", 64'(intf.req_ready), 64'd0);
    checkOutput("t3_full_busy",  64'(busy), 64'd0);
    checkOutput("t3_head0",      intf.rsp_prod, 64'd20);
    intf.rsp_ready = 1'b1;
    step();
    checkOutput("t3_head1",      intf.rsp_prod, 64'd30);
    checkOutput("t3_room_ready", 64'(intf.req_ready), 64'd1);
    step();
    intf.req_valid = 1'b0;
    checkOutput("t3_third_busy", 64'(busy), 64'd1);
    checkOutput("t3_empty",      64'(intf.rsp_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step();
      if (intf.rsp_valid) begin
        seen = 1;
        checkOutput("t3_third", intf.rsp_prod, 64'd40);
      end
    end
    checkOutput("t3_third_seen", 64'(seen), 64'd1);
    step();

    // T4 operand hold during BUSY
    issue(32'h1111_1111, 32'd2, 4'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_in0",   64'(mulIn0), 64'h1111_1111);
      checkOutput("t4_in1",   64'(mulIn1), 64'd2);
      checkOutput("t4_ready", 64'(intf.req_ready), 64'd0);
      applyStimulus(1'b1, $urandom, $urandom, 4'h0);
      step();
    end
    intf.req_valid = 1'b0;
    checkOutput("t4_prod",      intf.rsp_prod, 64'h2222_2222);
    checkOutput("t4_idle_hold", 64'(mulIn0), 64'h1111_1111);
    step();

    // T5 reset mid-operation with one queued response
    intf.rsp_ready = 1'b0;
    issue(32'd5, 32'd5, 4'h0);
    repeat (4) step();
    issue(32'd6, 32'd6, 4'h0);
    step(); step();
    rst = 1'b1;
    #1;
    checkOutput("t5_rsp_valid", 64'(intf.rsp_valid), 64'd0);
    checkOutput("t5_rsp_prod",  intf.rsp_prod, 64'd0);
    checkOutput("t5_busy",      64'(busy), 64'd0);
    checkOutput("t5_req_ready", 64'(intf.req_ready), 64'd1);
    checkOutput("t5_mul_in0",   64'(mulIn0), 64'd0);
    step();
    rst = 1'b0;
    intf.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (intf.rsp_valid) seen++;
      step();
    end
    checkOutput("t5_no_ghost", 64'(seen), 64'd0);
    runOp(32'd1, 32'hFFFF_FFFF, prod, lat, busyCnt);
    checkOutput("t5_after", prod, 64'hFFFF_FFFF_FFFF_FFFF);

`ifdef MUL_ISSUE_TAG_EN
    // T6 tags with simultaneous push and pop
    intf.rsp_ready = 1'b0;
    issue(32'd2, 32'd3, 4'h3);
    repeat (4) step();
    checkOutput("t6_tag0",  64'(intf.rsp_tag), 64'h3);
    checkOutput("t6_prod0", intf.rsp_prod, 64'd6);
    issue(32'd4, 32'd5, 4'hA);
    repeat (3) step();
    intf.rsp_ready = 1'b1;
    step();
    checkOutput("t6_valid1", 64'(intf.rsp_valid), 64'd1);
    checkOutput("t6_tag1",   64'(intf.rsp_tag), 64'hA);
    checkOutput("t6_prod1",  intf.rsp_prod, 64'd20);
    step();
    checkOutput("t6_drained", 64'(intf.rsp_valid), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
